// File: rtl/sys_bus_pkg.sv
//------------------------------------------------------------------------------
// Module   : sys_bus_pkg
// Purpose  : Shared constants for the system bus: store-size codes, region
//            decode, peripheral register offsets and timer CTRL bit positions.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package sys_bus_pkg;

    localparam int RAM_W_OP_WIDTH = 2;
    localparam logic [RAM_W_OP_WIDTH-1:0] RAM_W_OP_BYTE = 2'd0;
    localparam logic [RAM_W_OP_WIDTH-1:0] RAM_W_OP_HALF = 2'd1;
    localparam logic [RAM_W_OP_WIDTH-1:0] RAM_W_OP_WORD = 2'd2;

    localparam logic [31:0] c_periph_mask = 32'hFFFF_FF00;
    localparam logic [31:0] c_timer_base  = 32'h1000_0000;
    localparam logic [31:0] c_gpio_base   = 32'h2000_0000;

    // Offsets are word indices taken from adr[7:2]
    localparam logic [5:0] c_tmr_ctrl  = 6'd0;
    localparam logic [5:0] c_tmr_count = 6'd1;
    localparam logic [5:0] c_tmr_cmp   = 6'd2;
    localparam logic [5:0] c_gpio_out  = 6'd0;

    localparam int c_ctrl_en   = 0;
    localparam int c_ctrl_ie   = 1;
    localparam int c_ctrl_pend = 2;

    localparam logic [31:0] c_cmp_rst = 32'hFFFF_FFFF;

endpackage

`default_nettype wire

// File: rtl/sys_timer.sv
//------------------------------------------------------------------------------
// Module   : sys_timer
// Purpose  : Machine timer with prescaler, COUNT/CMP match, sticky pending
//            flag and a registered interrupt request.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sys_timer
    import sys_bus_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_wr_en,
    input  logic [5:0]  i_offset,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic        o_int_flag
);

    localparam logic [15:0] c_presc_last = 16'(PRESCALE - 1);

    logic [15:0] r_presc;
    logic [31:0] r_count;
    logic [31:0] r_cmp;
    logic        r_en;
    logic        r_ie;
    logic        r_pend;
    logic        r_int;

    logic w_wr_ctrl;
    logic w_wr_count;
    logic w_wr_cmp;
    logic w_run;
    logic w_tick;
    logic w_match;

    assign w_wr_ctrl  = i_wr_en && (i_offset == c_tmr_ctrl);
    assign w_wr_count = i_wr_en && (i_offset == c_tmr_count);
    assign w_wr_cmp   = i_wr_en && (i_offset == c_tmr_cmp);

    // A CTRL write that clears EN freezes the timer on that very edge
    assign w_run   = r_en && !(w_wr_ctrl && !i_wdata[c_ctrl_en]);
    assign w_tick  = w_run && (r_presc == c_presc_last);
    assign w_match = w_tick && !w_wr_count && (r_count == r_cmp);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= '0;
            r_count <= '0;
            r_cmp   <= c_cmp_rst;
            r_en    <= 1'b0;
            r_ie    <= 1'b0;
            r_pend  <= 1'b0;
            r_int   <= 1'b0;
        end else begin
            if (w_run) begin
                r_presc <= w_tick ? 16'd0 : r_presc + 16'd1;
            end
            if (w_wr_ctrl) begin
                r_en <= i_wdata[c_ctrl_en];
                r_ie <= i_wdata[c_ctrl_ie];
            end
            if (w_wr_count) begin
                r_count <= i_wdata;
            end else if (w_tick) begin
                r_count <= (r_count == r_cmp) ? 32'd0 : r_count + 32'd1;
            end
            if (w_wr_cmp) begin
                r_cmp <= i_wdata;
            end
            // Match-set has priority over write-1-clear
            if (w_match) begin
                r_pend <= 1'b1;
            end else if (w_wr_ctrl && i_wdata[c_ctrl_pend]) begin
                r_pend <= 1'b0;
            end
            r_int <= r_pend && r_ie;
        end
    end

    always_comb begin
        o_rdata = 32'd0;
        case (i_offset)
            c_tmr_ctrl:  o_rdata = {29'd0, r_pend, r_ie, r_en};
            c_tmr_count: o_rdata = r_count;
            c_tmr_cmp:   o_rdata = r_cmp;
            default:     o_rdata = 32'd0;
        endcase
    end

    assign o_int_flag = r_int;

endmodule

`default_nettype wire

// File: rtl/sys_bus.sv
//------------------------------------------------------------------------------
// Module   : sys_bus
// Purpose  : Single-master bus decode to data RAM, machine timer and GPIO
//            output register, with a combinational read-data mux.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sys_bus
    import sys_bus_pkg::*;
#(
    parameter int PRESCALE = 1,
    parameter int DRAM_AW  = 12
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      sys_bus_request,
    input  logic                      sys_bus_we,
    input  logic [31:0]               sys_bus_adr,
    input  logic [31:0]               sys_bus_wdata,
    input  logic [RAM_W_OP_WIDTH-1:0] dram_w_op,
    output logic [31:0]               sys_bus_rdata,
    output logic                      int_flag_o,
    output logic                      dram_en,
    output logic                      dram_we,
    output logic [31:0]               dram_adr,
    output logic [31:0]               dram_wdin,
    output logic [RAM_W_OP_WIDTH-1:0] dram_w_op_o,
    input  logic [31:0]               dram_rdo,
    output logic [31:0]               gpio_o
);

    logic        w_is_ram;
    logic        w_is_tmr;
    logic        w_is_gpio;
    logic [5:0]  w_off;
    logic        w_per_wr;
    logic [31:0] w_tmr_rdata;
    logic [31:0] r_gpio;

    assign w_is_ram  = (sys_bus_adr >> (DRAM_AW + 2)) == 32'd0;
    assign w_is_tmr  = (sys_bus_adr & c_periph_mask) == c_timer_base;
    assign w_is_gpio = (sys_bus_adr & c_periph_mask) == c_gpio_base;
    assign w_off     = sys_bus_adr[7:2];

    // Peripheral registers are word-only; narrower stores are dropped
    assign w_per_wr = sys_bus_request && sys_bus_we && (dram_w_op == RAM_W_OP_WORD);

    assign dram_en     = sys_bus_request && w_is_ram;
    assign dram_we     = dram_en && sys_bus_we;
    assign dram_adr    = sys_bus_adr;
    assign dram_wdin   = sys_bus_wdata;
    assign dram_w_op_o = dram_w_op;

    sys_timer #(
        .PRESCALE (PRESCALE)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_wr_en    (w_per_wr && w_is_tmr),
        .i_offset   (w_off),
        .i_wdata    (sys_bus_wdata),
        .o_rdata    (w_tmr_rdata),
        .o_int_flag (int_flag_o)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_gpio <= '0;
        end else if (w_per_wr && w_is_gpio && (w_off == c_gpio_out)) begin
            r_gpio <= sys_bus_wdata;
        end
    end

    assign gpio_o = r_gpio;

    always_comb begin
        sys_bus_rdata = 32'd0;
        if (sys_bus_request) begin
            if (w_is_ram) begin
                sys_bus_rdata = dram_rdo;
            end else if (w_is_tmr) begin
                sys_bus_rdata = w_tmr_rdata;
            end else if (w_is_gpio && (w_off == c_gpio_out)) begin
                sys_bus_rdata = r_gpio;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sys_bus.sv
//------------------------------------------------------------------------------
// Module   : tb_sys_bus
// Purpose  : Directed vector bench for sys_bus at PRESCALE=1 and PRESCALE=4.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_sys_bus;
    import sys_bus_pkg::*;

    localparam logic [31:0] c_t_ctrl  = 32'h1000_0000;
    localparam logic [31:0] c_t_count = 32'h1000_0004;
    localparam logic [31:0] c_t_cmp   = 32'h1000_0008;
    localparam logic [31:0] c_g_out   = 32'h2000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we  = 1'b0;
    logic [31:0] adr = '0;
    logic [31:0] wdata = '0;
    logic [1:0]  wop = RAM_W_OP_WORD;
    logic [31:0] rdo = '0;

    logic [31:0] rdata, rdata4, d_adr, d_adr4, d_wdin, d_wdin4, gpio, gpio4;
    logic        intf, intf4, d_en, d_en4, d_we, d_we4;
    logic [1:0]  d_wop, d_wop4;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sys_bus #(.PRESCALE(1), .DRAM_AW(12)) u_dut (
        .clk(clk), .rst(rst), .sys_bus_request(req), .sys_bus_we(we),
        .sys_bus_adr(adr), .sys_bus_wdata(wdata), .dram_w_op(wop),
        .sys_bus_rdata(rdata), .int_flag_o(intf), .dram_en(d_en), .dram_we(d_we),
        .dram_adr(d_adr), .dram_wdin(d_wdin), .dram_w_op_o(d_wop),
        .dram_rdo(rdo), .gpio_o(gpio)
    );

    sys_bus #(.PRESCALE(4), .DRAM_AW(12)) u_dut4 (
        .clk(clk), .rst(rst), .sys_bus_request(req), .sys_bus_we(we),
        .sys_bus_adr(adr), .sys_bus_wdata(wdata), .dram_w_op(wop),
        .sys_bus_rdata(rdata4), .int_flag_o(intf4), .dram_en(d_en4), .dram_we(d_we4),
        .dram_adr(d_adr4), .dram_wdin(d_wdin4), .dram_w_op_o(d_wop4),
        .dram_rdo(rdo), .gpio_o(gpio4)
    );

    typedef struct {
        logic        req;
        logic        we;
        logic [31:0] adr;
        logic [31:0] wdata;
        logic [1:0]  wop;
        logic [31:0] rdo;
        logic        chk_rd;
        logic [31:0] exp_rdata;
        logic        exp_en;
        logic        exp_we;
        logic [31:0] exp_gpio;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic go_idle();
        req = 1'b0; we = 1'b0; adr = '0; wdata = '0; wop = RAM_W_OP_WORD;
    endtask

    task automatic tick(input int n);
        go_idle();
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        req = 1'b1; we = 1'b1; adr = a; wdata = d; wop = RAM_W_OP_WORD;
        @(posedge clk);
        #1;
        go_idle();
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] r1, output logic [31:0] r4);
        req = 1'b1; we = 1'b0; adr = a;
        #1;
        r1 = rdata;
        r4 = rdata4;
    endtask

    initial begin : main
        logic [31:0] r1, r4;

        //          req   we    adr            wdata          wop            rdo           chk   exp_rdata      en    we    gpio
        vecs[0]  = '{1'b0, 1'b0, 32'h0,         32'h0,         RAM_W_OP_WORD, 32'h1111_1111, 1'b1, 32'h0,         1'b0, 1'b0, 32'h0};
        vecs[1]  = '{1'b1, 1'b0, c_t_cmp,       32'h0,         RAM_W_OP_WORD, 32'h0,         1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0};
        vecs[2]  = '{1'b1, 1'b0, c_t_ctrl,      32'h0,         RAM_W_OP_WORD, 32'h0,         1'b1, 32'h0,         1'b0, 1'b0, 32'h0};
        vecs[3]  = '{1'b1, 1'b1, 32'h10,        32'hDEAD_BEEF, RAM_W_OP_WORD, 32'h0,         1'b0, 32'h0,         1'b1, 1'b1, 32'h0};
        vecs[4]  = '{1'b1, 1'b0, 32'h10,        32'h0,         RAM_W_OP_WORD, 32'h1234_5678, 1'b1, 32'h1234_5678, 1'b1, 1'b0, 32'h0};
        vecs[5]  = '{1'b1, 1'b0, 32'h3000_0000, 32'h0,         RAM_W_OP_WORD, 32'hAAAA_5555, 1'b1, 32'h0,         1'b0, 1'b0, 32'h0};
        vecs[6]  = '{1'b1, 1'b1, c_g_out,       32'h55,        RAM_W_OP_BYTE, 32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 32'h0};
        vecs[7]  = '{1'b1, 1'b0, c_g_out,       32'h0,         RAM_W_OP_WORD, 32'h0,         1'b1, 32'h0,         1'b0, 1'b0, 32'h0};
        vecs[8]  = '{1'b1, 1'b1, c_g_out,       32'h55,        RAM_W_OP_WORD, 32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 32'h0};
        vecs[9]  = '{1'b1, 1'b0, c_g_out,       32'h0,         RAM_W_OP_WORD, 32'h0,         1'b1, 32'h55,        1'b0, 1'b0, 32'h55};
        vecs[10] = '{1'b1, 1'b0, 32'h2000_0004, 32'h0,         RAM_W_OP_WORD, 32'h0,         1'b1, 32'h0,         1'b0, 1'b0, 32'h55};
        vecs[11] = '{1'b1, 1'b1, c_t_cmp,       32'h7,         RAM_W_OP_HALF, 32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 32'h55};
        vecs[12] = '{1'b1, 1'b0, c_t_cmp,       32'h0,         RAM_W_OP_WORD, 32'h0,         1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h55};
        vecs[13] = '{1'b1, 1'b0, 32'h3FFC,      32'h0,         RAM_W_OP_WORD, 32'h0BAD_F00D, 1'b1, 32'h0BAD_F00D, 1'b1, 1'b0, 32'h55};
        vecs[14] = '{1'b1, 1'b0, 32'h4000,      32'h0,         RAM_W_OP_WORD, 32'h0BAD_F00D, 1'b1, 32'h0,         1'b0, 1'b0, 32'h55};
        vecs[15] = '{1'b1, 1'b1, c_t_count,     32'h100,       RAM_W_OP_WORD, 32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 32'h55};
        vecs[16] = '{1'b1, 1'b0, 32'h1000_0007, 32'h0,         RAM_W_OP_WORD, 32'h0,         1'b1, 32'h100,       1'b0, 1'b0, 32'h55};
        vecs[17] = '{1'b1, 1'b1, c_t_count,     32'h0,         RAM_W_OP_WORD, 32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 32'h55};
        vecs[18] = '{1'b1, 1'b0, c_t_count,     32'h0,         RAM_W_OP_WORD, 32'h0,         1'b1, 32'h0,         1'b0, 1'b0, 32'h55};
        vecs[19] = '{1'b0, 1'b1, c_g_out,       32'hFF,        RAM_W_OP_WORD, 32'h0,         1'b1, 32'h0,         1'b0, 1'b0, 32'h55};
        vecs[20] = '{1'b1, 1'b1, 32'h3000_0000, 32'hFF,        RAM_W_OP_WORD, 32'h0,         1'b0, 32'h0,         1'b0, 1'b0, 32'h55};
        vecs[21] = '{1'b1, 1'b0, c_g_out,       32'h0,         RAM_W_OP_WORD, 32'h0,         1'b1, 32'h55,        1'b0, 1'b0, 32'h55};

        go_idle();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_int", {31'd0, intf}, 32'h0);

        for (int i = 0; i < NV; i++) begin
            req = vecs[i].req; we = vecs[i].we; adr = vecs[i].adr;
            wdata = vecs[i].wdata; wop = vecs[i].wop; rdo = vecs[i].rdo;
            #1;
            if (vecs[i].chk_rd) check($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
            check($sformatf("v%0d_dram_en", i), {31'd0, d_en}, {31'd0, vecs[i].exp_en});
            check($sformatf("v%0d_dram_we", i), {31'd0, d_we}, {31'd0, vecs[i].exp_we});
            check($sformatf("v%0d_gpio", i), gpio, vecs[i].exp_gpio);
            if (i == 3) begin
                check("ram_wr_adr", d_adr, 32'h10);
                check("ram_wr_data", d_wdin, 32'hDEAD_BEEF);
                check("ram_wr_op", {30'd0, d_wop}, {30'd0, RAM_W_OP_WORD});
            end
            @(posedge clk);
            #1;
        end
        go_idle();

        // PRESCALE=1: count 0,1,2,3,0 with pend on the wrap edge
        bus_write(c_t_cmp, 32'd3);
        bus_write(c_t_ctrl, 32'h3);
        bus_read(c_t_count, r1, r4); check("p1_count0", r1, 32'd0);
        tick(1); bus_read(c_t_count, r1, r4); check("p1_count1", r1, 32'd1);
        tick(1); bus_read(c_t_count, r1, r4); check("p1_count2", r1, 32'd2);
        tick(1); bus_read(c_t_count, r1, r4); check("p1_count3", r1, 32'd3);
        bus_read(c_t_ctrl, r1, r4); check("p1_ctrl_pre", r1, 32'h3);
        tick(1); bus_read(c_t_count, r1, r4); check("p1_count_wrap", r1, 32'd0);
        bus_read(c_t_ctrl, r1, r4); check("p1_pend_set", r1, 32'h7);
        check("p1_int_lag", {31'd0, intf}, 32'h0);
        tick(1); check("p1_int_rise", {31'd0, intf}, 32'h1);
        bus_write(c_t_ctrl, 32'h7);
        check("w1c_int_still", {31'd0, intf}, 32'h1);
        bus_read(c_t_ctrl, r1, r4); check("w1c_pend_clr", r1, 32'h3);
        tick(1); check("w1c_int_drop", {31'd0, intf}, 32'h0);
        bus_read(c_t_count, r1, r4); check("w1c_running", r1, 32'd3);

        // Write-1-clear on a match edge: set wins
        bus_write(c_t_ctrl, 32'h7);
        bus_read(c_t_ctrl, r1, r4); check("w1c_vs_match", r1, 32'h7);
        bus_read(c_t_count, r1, r4); check("w1c_match_cnt", r1, 32'd0);

        // COUNT write on a match edge: value loads, no pend
        bus_write(c_t_ctrl, 32'h7);
        tick(2);
        bus_read(c_t_count, r1, r4); check("cw_pre", r1, 32'd3);
        bus_write(c_t_count, 32'h10);
        bus_read(c_t_count, r1, r4); check("cw_count", r1, 32'h10);
        bus_read(c_t_ctrl, r1, r4); check("cw_no_pend", r1, 32'h3);
        tick(1); bus_read(c_t_count, r1, r4); check("cw_next", r1, 32'h11);

        // Reset mid-operation with an active interrupt
        bus_write(c_t_count, 32'd3);
        tick(2);
        check("rst_int_pre", {31'd0, intf}, 32'h1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_int", {31'd0, intf}, 32'h0);
        check("rst_gpio", gpio, 32'h0);
        check("rst_gpio4", gpio4, 32'h0);
        check("rst_rdata_idle", rdata, 32'h0);
        bus_read(c_t_cmp, r1, r4); check("rst_cmp", r1, 32'hFFFF_FFFF);
        bus_read(c_t_ctrl, r1, r4); check("rst_ctrl", r1, 32'h0);
        tick(1); bus_read(c_t_count, r1, r4); check("rst_count", r1, 32'h0);

        // PRESCALE=4: tick every 4 clocks; EN-clear freezes and suppresses a due tick
        bus_write(c_t_ctrl, 32'h1);
        tick(3); bus_read(c_t_count, r1, r4); check("p4_c0", r4, 32'd0);
        tick(1); bus_read(c_t_count, r1, r4); check("p4_c1", r4, 32'd1);
        tick(3); bus_read(c_t_count, r1, r4); check("p4_c1_hold", r4, 32'd1);
        tick(1); bus_read(c_t_count, r1, r4); check("p4_c2", r4, 32'd2);
        tick(3);
        bus_write(c_t_ctrl, 32'h0);
        bus_read(c_t_count, r1, r4); check("p4_suppress", r4, 32'd2);
        tick(2); bus_read(c_t_count, r1, r4); check("p4_frozen", r4, 32'd2);
        bus_write(c_t_ctrl, 32'h1);
        bus_read(c_t_count, r1, r4); check("p4_resume0", r4, 32'd2);
        tick(1); bus_read(c_t_count, r1, r4); check("p4_phase_kept", r4, 32'd3);

        go_idle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
